// File: rtl/huff_bit_packer.sv
// Huffman bit packer: per-symbol code table, MSB-first bit accumulator and
// fixed-width packed word output with zero-padded end-of-frame flush.
module huff_bit_packer #(
  parameter int SYM_W        = 8,
  parameter int MAX_CODE_LEN = 16,
  parameter int OUT_W        = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  tbl_wr_en,
  input  logic [SYM_W-1:0]                      tbl_wr_sym,
  input  logic [MAX_CODE_LEN-1:0]               tbl_wr_code,
  input  logic [$clog2(MAX_CODE_LEN+1)-1:0]     tbl_wr_len,
  input  logic                                  sym_valid,
  output logic                                  sym_ready,
  input  logic [SYM_W-1:0]                      sym_data,
  input  logic                                  sym_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_W-1:0]                      out_data,
  output logic [$clog2(OUT_W+1)-1:0]            out_nbits,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  err_len0
);

  localparam int DEPTH  = 1 << SYM_W;
  localparam int LEN_W  = $clog2(MAX_CODE_LEN + 1);
  localparam int NB_W   = $clog2(OUT_W + 1);
  localparam int ACC_W  = OUT_W + MAX_CODE_LEN;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_CODE_LEN);
  localparam logic [FILL_W-1:0] WORD_LEN = FILL_W'(OUT_W);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state;
  logic [MAX_CODE_LEN-1:0] tbl_code [DEPTH];
  logic [LEN_W-1:0]        tbl_len  [DEPTH];
  logic [ACC_W-1:0]        acc;
  logic [FILL_W-1:0]       fill;

  logic [MAX_CODE_LEN-1:0] lk_code;
  logic [LEN_W-1:0]        lk_len;
  logic [LEN_W-1:0]        shift_amt;
  logic [MAX_CODE_LEN-1:0] code_mask;
  logic [ACC_W-1:0]        code_ext;
  logic [ACC_W-1:0]        code_pos;
  logic                    fill_ge;
  logic                    out_free;
  logic                    accept;

  // Left-align the code inside the accumulator width, then drop it at bit position fill.
  always_comb begin
    lk_code   = tbl_code[sym_data];
    lk_len    = tbl_len[sym_data];
    shift_amt = MAX_LEN - lk_len;
    code_mask = {MAX_CODE_LEN{1'b1}} >> shift_amt;
    code_ext  = {lk_code & code_mask, {OUT_W{1'b0}}};
    code_pos  = (code_ext << shift_amt) >> fill;
  end

  assign fill_ge   = (fill >= WORD_LEN);
  assign out_free  = !out_valid || out_ready;
  assign sym_ready = !reset && (state == RUN) && !fill_ge;
  assign accept    = sym_valid && sym_ready;
  assign busy      = (fill != '0) || out_valid || (state == FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_code[i] <= '0;
        tbl_len[i]  <= '0;
      end
      acc       <= '0;
      fill      <= '0;
      state     <= RUN;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
      err_len0  <= 1'b0;
    end else begin
      if (tbl_wr_en) begin
        tbl_code[tbl_wr_sym] <= tbl_wr_code;
        tbl_len[tbl_wr_sym]  <= tbl_wr_len;
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Accept and word transfer never coincide: accepting needs fill below one word.
      if (accept) begin
        acc  <= acc | code_pos;
        fill <= fill + FILL_W'(lk_len);
        if (lk_len == '0) begin
          err_len0 <= 1'b1;
        end
        if (sym_last) begin
          state <= FLUSH;
        end
      end else if (fill_ge && out_free) begin
        out_valid <= 1'b1;
        out_data  <= acc[ACC_W-1 -: OUT_W];
        out_nbits <= NB_W'(OUT_W);
        acc       <= acc << OUT_W;
        fill      <= fill - WORD_LEN;
        if ((state == FLUSH) && (fill == WORD_LEN)) begin
          out_last <= 1'b1;
          state    <= RUN;
        end else begin
          out_last <= 1'b0;
        end
      end else if ((state == FLUSH) && out_free) begin
        // Bits below fill are always zero, so the top slice is already padded.
        out_valid <= 1'b1;
        out_data  <= acc[ACC_W-1 -: OUT_W];
        out_nbits <= NB_W'(fill);
        out_last  <= 1'b1;
        acc       <= '0;
        fill      <= '0;
        state     <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Self-checking bench for huff_bit_packer: directed frame table, hand-written
// backpressure/reset sequences and random frames against a bit-queue model.
module tb_huff_bit_packer;

  localparam int SYM_W = 8;
  localparam int MCL   = 16;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             tbl_wr_en;
  logic [SYM_W-1:0] tbl_wr_sym;
  logic [MCL-1:0]   tbl_wr_code;
  logic [4:0]       tbl_wr_len;
  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym_data;
  logic             sym_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [5:0]       out_nbits;
  logic             out_last;
  logic             busy;
  logic             err_len0;

  logic ready_man = 1'b1;
  logic bp_rand   = 1'b1;
  logic rand_bp   = 1'b0;

  always #5 clk = ~clk;

  assign out_ready = rand_bp ? bp_rand : ready_man;

  huff_bit_packer #(.SYM_W(SYM_W), .MAX_CODE_LEN(MCL), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_sym(tbl_wr_sym), .tbl_wr_code(tbl_wr_code), .tbl_wr_len(tbl_wr_len),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_nbits(out_nbits),
    .out_last(out_last), .busy(busy), .err_len0(err_len0)
  );

  always @(posedge clk) begin
    #1;
    bp_rand = ($urandom_range(0, 3) != 0);
  end

  // Received words, captured mid-cycle when the handshake will complete at the next edge.
  logic [OUT_W-1:0] rx_data[$];
  int               rx_nbits[$];
  bit               rx_last[$];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_nbits.push_back(int'(out_nbits));
      rx_last.push_back(out_last);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: code table plus an unbounded bit queue cut into words.
  logic [MCL-1:0]   mcode[256];
  int               mlen[256];
  bit               mbits[$];
  logic [OUT_W-1:0] exp_data[$];
  int               exp_nbits[$];
  bit               exp_last[$];

  task automatic modelWord(input int n, input bit last);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int j = 0; j < n; j++) w[OUT_W-1-j] = mbits.pop_front();
    exp_data.push_back(w);
    exp_nbits.push_back(n);
    exp_last.push_back(last);
  endtask

  task automatic modelSym(input int sym, input bit last);
    bit emitted;
    emitted = 1'b0;
    for (int i = mlen[sym] - 1; i >= 0; i--) mbits.push_back(mcode[sym][i]);
    while (mbits.size() >= OUT_W) begin
      modelWord(OUT_W, 1'b0);
      emitted = 1'b1;
    end
    if (last) begin
      if (mbits.size() > 0) modelWord(mbits.size(), 1'b1);
      else if (emitted) exp_last[exp_last.size()-1] = 1'b1;
      else modelWord(0, 1'b1);
    end
  endtask

  task automatic loadEntry(input int sym, input logic [MCL-1:0] code, input int len);
    tbl_wr_en   = 1'b1;
    tbl_wr_sym  = SYM_W'(sym);
    tbl_wr_code = code;
    tbl_wr_len  = 5'(len);
    @(posedge clk); #1;
    tbl_wr_en = 1'b0;
    mcode[sym] = code;
    mlen[sym]  = len;
  endtask

  task automatic applyStimulus(input logic [7:0] sym, input bit last);
    int k;
    sym_valid = 1'b1;
    sym_data  = sym;
    sym_last  = last;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sym_ready && k < 200);
    if (!sym_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL sym_accept_timeout: got sym_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic waitWords(input int base, input int n);
    int k;
    k = 0;
    while (((rx_data.size() - base) < n || busy) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int s = 0; s < 256; s++) begin
      mcode[s] = '0;
      mlen[s]  = 0;
    end
  endtask

  typedef struct {
    string       name;
    string       syms;
    int          nwords;
    logic [31:0] d0;
    int          n0;
    bit          l0;
    logic [31:0] d1;
    int          n1;
    bit          l1;
    bit          err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base;
    int ebase;
    int nexp;

    vecs[0] = '{"basic",    "anu",              1, 32'h58000000,  5, 1'b1, 32'h0,          0, 1'b0, 1'b0};
    vecs[1] = '{"exact",    "nnnnnnnnnnnnnnnn", 1, 32'hAAAAAAAA, 32, 1'b1, 32'h0,          0, 1'b0, 1'b0};
    vecs[2] = '{"straddle", "FFF",              2, 32'hFFFFFFFF, 32, 1'b0, 32'hFFFF0000, 16, 1'b1, 1'b0};
    vecs[3] = '{"len0",     "z",                1, 32'h00000000,  0, 1'b1, 32'h0,          0, 1'b0, 1'b1};

    reset = 1'b1; tbl_wr_en = 1'b0; tbl_wr_sym = '0; tbl_wr_code = '0; tbl_wr_len = '0;
    sym_valid = 1'b0; sym_data = '0; sym_last = 1'b0;
    for (int s = 0; s < 256; s++) begin mcode[s] = '0; mlen[s] = 0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sym_ready", 64'(sym_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data",  64'(out_data),  64'd0);
    checkOutput("rst_out_nbits", 64'(out_nbits), 64'd0);
    checkOutput("rst_out_last",  64'(out_last),  64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_err_len0",  64'(err_len0),  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    loadEntry("a", 16'h0000, 1);
    loadEntry("n", 16'h0002, 2);
    loadEntry("u", 16'h0003, 2);
    loadEntry("F", 16'hFFFF, 16);

    for (int v = 0; v < 4; v++) begin
      base = rx_data.size();
      for (int c = 0; c < vecs[v].syms.len(); c++)
        applyStimulus(vecs[v].syms[c], c == vecs[v].syms.len() - 1);
      waitWords(base, vecs[v].nwords);
      checkOutput({vecs[v].name, "_count"}, 64'(rx_data.size() - base), 64'(vecs[v].nwords));
      if (rx_data.size() - base >= 1) begin
        checkOutput({vecs[v].name, "_w0_data"},  64'(rx_data[base]),  64'(vecs[v].d0));
        checkOutput({vecs[v].name, "_w0_nbits"}, 64'(rx_nbits[base]), 64'(vecs[v].n0));
        checkOutput({vecs[v].name, "_w0_last"},  64'(rx_last[base]),  64'(vecs[v].l0));
      end
      if (vecs[v].nwords > 1 && rx_data.size() - base >= 2) begin
        checkOutput({vecs[v].name, "_w1_data"},  64'(rx_data[base+1]),  64'(vecs[v].d1));
        checkOutput({vecs[v].name, "_w1_nbits"}, 64'(rx_nbits[base+1]), 64'(vecs[v].n1));
        checkOutput({vecs[v].name, "_w1_last"},  64'(rx_last[base+1]),  64'(vecs[v].l1));
      end
      checkOutput({vecs[v].name, "_err_len0"}, 64'(err_len0), 64'(vecs[v].err));
    end

    // Backpressure: the first word must hold while the third symbol is absorbed.
    ready_man = 1'b0;
    base = rx_data.size();
    applyStimulus("F", 1'b0);
    applyStimulus("F", 1'b0);
    applyStimulus("F", 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_data",  64'(out_data),  64'hFFFFFFFF);
      checkOutput("bp_hold_last",  64'(out_last),  64'd0);
      checkOutput("bp_sym_ready",  64'(sym_ready), 64'd0);
    end
    @(posedge clk); #1;
    ready_man = 1'b1;
    waitWords(base, 2);
    checkOutput("bp_count", 64'(rx_data.size() - base), 64'd2);
    if (rx_data.size() - base >= 2) begin
      checkOutput("bp_w0_data",  64'(rx_data[base]),    64'hFFFFFFFF);
      checkOutput("bp_w0_last",  64'(rx_last[base]),    64'd0);
      checkOutput("bp_w1_data",  64'(rx_data[base+1]),  64'hFFFF0000);
      checkOutput("bp_w1_nbits", 64'(rx_nbits[base+1]), 64'd16);
      checkOutput("bp_w1_last",  64'(rx_last[base+1]),  64'd1);
    end

    // Reset mid-frame: partial bits and the sticky error vanish, table reverts to length 0.
    base = rx_data.size();
    applyStimulus("a", 1'b0);
    applyStimulus("n", 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_sym_ready", 64'(sym_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int s = 0; s < 256; s++) begin mcode[s] = '0; mlen[s] = 0; end
    @(negedge clk);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_out_data",  64'(out_data),  64'd0);
    checkOutput("mid_rst_out_nbits", 64'(out_nbits), 64'd0);
    checkOutput("mid_rst_out_last",  64'(out_last),  64'd0);
    checkOutput("mid_rst_busy",      64'(busy),      64'd0);
    checkOutput("mid_rst_err_len0",  64'(err_len0),  64'd0);
    checkOutput("mid_rst_no_word",   64'(rx_data.size() - base), 64'd0);
    @(posedge clk); #1;
    base = rx_data.size();
    applyStimulus("n", 1'b1);
    waitWords(base, 1);
    checkOutput("cleared_tbl_count", 64'(rx_data.size() - base), 64'd1);
    if (rx_data.size() - base >= 1) begin
      checkOutput("cleared_tbl_nbits", 64'(rx_nbits[base]), 64'd0);
      checkOutput("cleared_tbl_data",  64'(rx_data[base]),  64'd0);
      checkOutput("cleared_tbl_last",  64'(rx_last[base]),  64'd1);
    end
    checkOutput("cleared_tbl_err_len0", 64'(err_len0), 64'd1);

    // Random table and frames under random backpressure.
    pulseReset();
    for (int s = 0; s < 256; s++) begin
      int len;
      logic [MCL-1:0] code;
      len  = $urandom_range(1, MCL);
      code = MCL'($urandom) & MCL'((32'd1 << len) - 1);
      loadEntry(s, code, len);
    end
    rand_bp = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int nsym;
      base  = rx_data.size();
      ebase = exp_data.size();
      nsym  = $urandom_range(1, 24);
      for (int i = 0; i < nsym; i++) begin
        int sym;
        sym = $urandom_range(0, 255);
        modelSym(sym, i == nsym - 1);
        applyStimulus(8'(sym), i == nsym - 1);
      end
      nexp = exp_data.size() - ebase;
      waitWords(base, nexp);
      checkOutput("rand_count", 64'(rx_data.size() - base), 64'(nexp));
      for (int i = 0; i < nexp; i++) begin
        if (base + i < rx_data.size()) begin
          checkOutput("rand_data",  64'(rx_data[base+i]),  64'(exp_data[ebase+i]));
          checkOutput("rand_nbits", 64'(rx_nbits[base+i]), 64'(exp_nbits[ebase+i]));
          checkOutput("rand_last",  64'(rx_last[base+i]),  64'(exp_last[ebase+i]));
        end
      end
    end
    rand_bp = 1'b0;
    checkOutput("rand_err_len0", 64'(err_len0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
